// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: PC generation, in-order imem requests and a prefetch FIFO feeding decode.
// Define FETCH_PERF_EN to add the perf_fetched / perf_starve counter outputs.
module riscv_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              dec_valid,
    output logic [31:0]       dec_instr,
    output logic [ADDR_W-1:0] dec_pc,
    input  logic              dec_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_starve
`endif
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  fifo_count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [31:0]       fifo_instr [DEPTH];
    logic [ADDR_W-1:0] fifo_pc    [DEPTH];

    logic              fifo_empty;
    logic              req_fire;
    logic              rsp_accept;
    logic              push;
    logic              pop;
    logic [CNT_W:0]    occupancy;
    logic [ADDR_W-1:0] redirect_aligned;

    // Outstanding requests plus buffered entries never exceed DEPTH, so a push always finds space.
    assign occupancy        = {1'b0, outstanding} + {1'b0, fifo_count};
    assign fifo_empty       = (fifo_count == '0);
    assign imem_req_valid   = rst_n && !redirect_valid && (occupancy < {1'b0, DEPTH_C});
    assign imem_req_addr    = fetch_pc;
    assign req_fire         = imem_req_valid && imem_req_ready;
    assign rsp_accept       = imem_rsp_valid && (outstanding != '0);
    assign push             = rst_n && !redirect_valid && rsp_accept && (drop_cnt == '0);
    assign pop              = dec_valid && dec_ready;
    assign redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};

    assign dec_valid = !fifo_empty;
    assign dec_instr = fifo_empty ? '0 : fifo_instr[rd_ptr];
    assign dec_pc    = fifo_empty ? '0 : fifo_pc[rd_ptr];

    // A redirect turns every request still in flight into a response to discard.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_aligned;
            rsp_pc      <= redirect_aligned;
            outstanding <= outstanding - CNT_W'(rsp_accept);
            drop_cnt    <= outstanding - CNT_W'(rsp_accept);
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + ADDR_W'(4);
            end
            if (push) begin
                rsp_pc <= rsp_pc + ADDR_W'(4);
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (rsp_accept && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_accept);
            fifo_count  <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr]    <= rsp_pc;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_starve  <= '0;
        end else begin
            if (push && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (dec_ready && !dec_valid && (perf_starve != '1)) begin
                perf_starve <= perf_starve + 32'd1;
            end
        end
    end
`endif

    assert property (@(posedge clk) disable iff (!rst_n) outstanding <= DEPTH_C);
    assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= DEPTH_C);

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: in-order memory model with random latency and a queue-based
// reference of which fetched words decode must see, plus directed scenarios with literal expectations.
module tb_riscv_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_starve;
`endif

    riscv_fetch_unit #(
        .ADDR_W  (32),
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .dec_valid     (dec_valid),
        .dec_instr     (dec_instr),
        .dec_pc        (dec_pc),
        .dec_ready     (dec_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_starve   (perf_starve)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic keep; } inflight_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
    typedef struct { logic [31:0] addr; int due; } memreq_t;

    inflight_t   inflight[$];
    entry_t      exp_q[$];
    memreq_t     mem_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] m_fetch_pc = RESET_PC;
    longint      m_fetched = 0;
    longint      m_starve = 0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic        tb_rst = 1'b0;
    int          p_req_ready = 100;
    int          p_dec_ready = 100;
    int          p_rsp = 100;
    int          p_redirect = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic        force_redirect = 1'b0;
    logic        redirect_on_rsp = 1'b0;
    logic [31:0] force_target = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0], addr[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // One clock cycle: drive at negedge, compare just before posedge, advance models at posedge.
    task automatic applyStimulus();
        logic        exp_req;
        logic        rsp_now;
        logic        model_acc;
        logic        dut_acc;
        logic        dut_pop;
        logic        model_pop;
        logic        starve;
        logic [31:0] acc_addr;
        logic [31:0] pop_pc;
        inflight_t   e;
        exp_req = 1'b0;
        @(negedge clk);
        rst_n          = tb_rst;
        imem_req_ready = (int'($urandom_range(99)) < p_req_ready);
        dec_ready      = (int'($urandom_range(99)) < p_dec_ready);
        rsp_now = 1'b0;
        if (mem_q.size() > 0) begin
            if (mem_q[0].due <= cyc && int'($urandom_range(99)) < p_rsp) rsp_now = 1'b1;
        end
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? mem_word(mem_q[0].addr) : $urandom;
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
        if (redirect_on_rsp && rsp_now) begin
            redirect_valid  = 1'b1;
            redirect_pc     = force_target;
            redirect_on_rsp = 1'b0;
        end else if (force_redirect) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_target;
            force_redirect = 1'b0;
        end else if (p_redirect > 0 && int'($urandom_range(99)) < p_redirect) begin
            redirect_valid = 1'b1;
        end
        #2;
        if (!rst_n) begin
            checkOutput("req_valid_in_reset", {31'd0, imem_req_valid}, 32'd0);
        end else begin
            exp_req = !redirect_valid && (inflight.size() + exp_q.size() < DEPTH);
            checkOutput("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req});
            if (exp_req) checkOutput("req_addr", imem_req_addr, m_fetch_pc);
            checkOutput("dec_valid", {31'd0, dec_valid}, {31'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                checkOutput("dec_pc", dec_pc, exp_q[0].pc);
                checkOutput("dec_instr", dec_instr, exp_q[0].instr);
            end
`ifdef FETCH_PERF_EN
            checkOutput("perf_fetched", perf_fetched, m_fetched[31:0]);
            checkOutput("perf_starve", perf_starve, m_starve[31:0]);
`endif
        end
        dut_acc   = imem_req_valid && imem_req_ready;
        acc_addr  = imem_req_addr;
        dut_pop   = rst_n && dec_valid && dec_ready;
        pop_pc    = dec_pc;
        model_acc = rst_n && exp_req && imem_req_ready;
        model_pop = rst_n && (exp_q.size() != 0) && dec_ready;
        starve    = rst_n && dec_ready && (exp_q.size() == 0);
        @(posedge clk);
        cyc++;
        if (rsp_now) void'(mem_q.pop_front());
        if (dut_acc) begin
            mem_q.push_back('{addr: acc_addr, due: cyc + int'($urandom_range(lat_max, lat_min)) - 1});
            acc_log.push_back(acc_addr);
        end
        if (dut_pop) pop_log.push_back(pop_pc);
        if (starve) m_starve++;
        if (!rst_n) begin
            inflight.delete();
            exp_q.delete();
            m_fetch_pc = RESET_PC;
            m_fetched  = 0;
            m_starve   = 0;
        end else if (redirect_valid) begin
            if (rsp_now && inflight.size() > 0) void'(inflight.pop_front());
            foreach (inflight[i]) inflight[i].keep = 1'b0;
            exp_q.delete();
            m_fetch_pc = {redirect_pc[31:2], 2'b00};
            acc_log.delete();
            pop_log.delete();
        end else begin
            if (model_pop) void'(exp_q.pop_front());
            if (rsp_now && inflight.size() > 0) begin
                e = inflight.pop_front();
                if (e.keep) begin
                    exp_q.push_back('{pc: e.addr, instr: mem_word(e.addr)});
                    m_fetched++;
                end
            end
            if (model_acc) begin
                inflight.push_back('{addr: m_fetch_pc, keep: 1'b1});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
    endtask

    // Reset with memory stalled, let stray responses drain, then pin the post-reset outputs.
    task automatic doReset();
        tb_rst      = 1'b0;
        p_req_ready = 0;
        p_redirect  = 0;
        repeat (2) applyStimulus();
        #1;
        checkOutput("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        checkOutput("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
        checkOutput("rst_dec_instr", dec_instr, 32'd0);
        checkOutput("rst_dec_pc", dec_pc, 32'd0);
`ifdef FETCH_PERF_EN
        checkOutput("rst_perf_fetched", perf_fetched, 32'd0);
        checkOutput("rst_perf_starve", perf_starve, 32'd0);
`endif
        tb_rst = 1'b1;
        applyStimulus();
        for (int i = 0; i < 60 && mem_q.size() > 0; i++) applyStimulus();
        if (mem_q.size() > 0) timeoutFail("reset_drain");
        #1;
        checkOutput("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
        checkOutput("post_rst_req_addr", imem_req_addr, RESET_PC);
        checkOutput("post_rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    endtask

    initial begin
        // Steady stream with single-cycle memory.
        lat_min = 1; lat_max = 1; p_rsp = 100;
        doReset();
        p_req_ready = 100; p_dec_ready = 100;
        acc_log.delete(); pop_log.delete();
        repeat (20) applyStimulus();
        checkOutput("s1_acc0", acc_log[0], 32'h0);
        checkOutput("s1_acc1", acc_log[1], 32'h4);
        checkOutput("s1_acc2", acc_log[2], 32'h8);
        checkOutput("s1_pop0", pop_log[0], 32'h0);
        checkOutput("s1_pop1", pop_log[1], 32'h4);
        checkOutput("s1_pop2", pop_log[2], 32'h8);
        checkOutput("s1_pop_count", pop_log.size(), 32'd18);

        // Decode stalled: issue stops at DEPTH requests.
        doReset();
        p_req_ready = 100; p_dec_ready = 0;
        acc_log.delete();
        repeat (20) applyStimulus();
        #1;
        checkOutput("s2_req_count", acc_log.size(), 32'd4);
        checkOutput("s2_req_valid", {31'd0, imem_req_valid}, 32'd0);
        checkOutput("s2_dec_valid", {31'd0, dec_valid}, 32'd1);
        checkOutput("s2_dec_pc", dec_pc, 32'h0);
        checkOutput("s2_dec_instr", dec_instr, mem_word(32'h0));

        // Latency 3, redirect with three requests in flight.
        doReset();
        lat_min = 3; lat_max = 3;
        p_req_ready = 100; p_dec_ready = 100;
        for (int i = 0; i < 20 && inflight.size() != 3; i++) applyStimulus();
        if (inflight.size() != 3) timeoutFail("s3_reach_outstanding");
        force_target = 32'h0000_0100; force_redirect = 1'b1;
        applyStimulus();
        for (int i = 0; i < 40 && pop_log.size() == 0; i++) applyStimulus();
        if (pop_log.size() == 0) timeoutFail("s3_first_decode");
        else checkOutput("s3_first_pc", pop_log[0], 32'h0000_0100);

        // Redirect landing on a response cycle with memory ready.
        lat_min = 2; lat_max = 2;
        repeat (6) applyStimulus();
        force_target = 32'h0000_0200; redirect_on_rsp = 1'b1;
        for (int i = 0; i < 30 && redirect_on_rsp; i++) applyStimulus();
        if (redirect_on_rsp) begin
            redirect_on_rsp = 1'b0;
            timeoutFail("s4_coincident_redirect");
        end
        for (int i = 0; i < 30 && (acc_log.size() == 0 || pop_log.size() == 0); i++) applyStimulus();
        if (acc_log.size() == 0 || pop_log.size() == 0) timeoutFail("s4_after_redirect");
        else begin
            checkOutput("s4_first_req", acc_log[0], 32'h0000_0200);
            checkOutput("s4_first_pc", pop_log[0], 32'h0000_0200);
        end

        // Unaligned redirect target and address wrap.
        force_target = 32'h0000_0103; force_redirect = 1'b1;
        applyStimulus();
        for (int i = 0; i < 20 && acc_log.size() == 0; i++) applyStimulus();
        if (acc_log.size() == 0) timeoutFail("s5_align");
        else checkOutput("s5_align_req", acc_log[0], 32'h0000_0100);
        force_target = 32'hFFFF_FFF8; force_redirect = 1'b1;
        applyStimulus();
        for (int i = 0; i < 30 && acc_log.size() < 3; i++) applyStimulus();
        if (acc_log.size() < 3) timeoutFail("s5_wrap");
        else begin
            checkOutput("s5_wrap0", acc_log[0], 32'hFFFF_FFF8);
            checkOutput("s5_wrap1", acc_log[1], 32'hFFFF_FFFC);
            checkOutput("s5_wrap2", acc_log[2], 32'h0000_0000);
        end

        // Reset with two requests in flight; their responses arrive as strays.
        doReset();
        lat_min = 6; lat_max = 6;
        p_req_ready = 100; p_dec_ready = 100;
        for (int i = 0; i < 20 && inflight.size() != 2; i++) applyStimulus();
        if (inflight.size() != 2) timeoutFail("s6_reach_outstanding");
        doReset();

        // Randomized traffic.
        lat_min = 1; lat_max = 5;
        p_req_ready = 70; p_dec_ready = 60; p_rsp = 80; p_redirect = 3;
        repeat (3000) applyStimulus();
        p_redirect = 0; p_dec_ready = 100; p_rsp = 100;
        repeat (30) applyStimulus();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
